pipe_adder: RTL and testbench

Two-stage pipelined 16-bit adder with valid/ready handshakes and status flags. It is the addition counterpart of the registered subtractor in the ALU datapath. The carry chain is split into two 8-bit slices so each stage carries half the ripple delay. It accepts one operand pair per cycle and buffers up to two results under downstream backpressure. It feeds the ALU result mux and the flag register.

---
 rtl/alu_pkg.sv | 15 +
 rtl/add_slice.sv | 15 +
 rtl/pipe_adder.sv | 120 ++++++++++++
 tb/tb_pipe_adder.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU datapath types and widths.
// Used by the adder, the subtractor and the flag register.
package alu_pkg;

  localparam int ALU_WIDTH = 16;
  localparam int ALU_HALF  = ALU_WIDTH / 2;

  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
    logic neg;
  } alu_flags_t;

endpackage

// File: rtl/add_slice.sv
// N-bit combinational ripple slice with carry in and out.
// Two of these split the 16-bit carry chain across pipe stages.
module add_slice #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};

endmodule

// File: rtl/pipe_adder.sv
// Two-stage pipelined adder with valid/ready handshake and flags.
// Low slice resolves in S1, high slice and flags in S2.
module pipe_adder
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int L = WIDTH / 2;
  localparam int H = WIDTH - L;

  logic             v1_q, v1_d;
  logic             v2_q, v2_d;
  logic [L-1:0]     lo_q, lo_d;
  logic             c1_q, c1_d;
  logic [H-1:0]     ahi_q, ahi_d;
  logic [H-1:0]     bhi_q, bhi_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  alu_flags_t       flg_q, flg_d;

  logic [L-1:0] s1_lo;
  logic         s1_c;
  logic [H-1:0] s2_hi;
  logic         s2_c;
  logic         s1_load;
  logic         s2_load;

  add_slice #(.N(L)) u_lo (
    .a    (a[L-1:0]),
    .b    (b[L-1:0]),
    .cin  (cin),
    .sum  (s1_lo),
    .cout (s1_c)
  );

  add_slice #(.N(H)) u_hi (
    .a    (ahi_q),
    .b    (bhi_q),
    .cin  (c1_q),
    .sum  (s2_hi),
    .cout (s2_c)
  );

  always_comb begin
    s2_load  = v1_q && (!v2_q || out_ready);
    // reset gates ready so nothing is sampled while held in reset
    in_ready = rst && (!v1_q || !v2_q || out_ready);
    s1_load  = in_valid && in_ready;

    v1_d  = s1_load || (v1_q && !s2_load);
    v2_d  = s2_load || (v2_q && !out_ready);
    lo_d  = lo_q;
    c1_d  = c1_q;
    ahi_d = ahi_q;
    bhi_d = bhi_q;
    sum_d = sum_q;
    flg_d = flg_q;

    if (s1_load) begin
      lo_d  = s1_lo;
      c1_d  = s1_c;
      ahi_d = a[WIDTH-1:L];
      bhi_d = b[WIDTH-1:L];
    end

    if (s2_load) begin
      sum_d      = {s2_hi, lo_q};
      flg_d.cout = s2_c;
      flg_d.ovf  = (ahi_q[H-1] == bhi_q[H-1]) &&
                   (s2_hi[H-1] != ahi_q[H-1]);
      flg_d.zero = ({s2_hi, lo_q} == '0);
      flg_d.neg  = s2_hi[H-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      lo_q  <= '0;
      c1_q  <= 1'b0;
      ahi_q <= '0;
      bhi_q <= '0;
      sum_q <= '0;
      flg_q <= '0;
    end else begin
      v1_q  <= v1_d;
      v2_q  <= v2_d;
      lo_q  <= lo_d;
      c1_q  <= c1_d;
      ahi_q <= ahi_d;
      bhi_q <= bhi_d;
      sum_q <= sum_d;
      flg_q <= flg_d;
    end
  end

  assign out_valid = v2_q;
  assign sum       = sum_q;
  assign cout      = flg_q.cout;
  assign ovf       = flg_q.ovf;
  assign zero      = flg_q.zero;
  assign neg       = flg_q.neg;

endmodule

// File: tb/tb_pipe_adder.sv
// Bench for pipe_adder: directed table, backpressure, reset
// and random streaming against an arithmetic reference model.
module tb_pipe_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;
  logic        zero;
  logic        neg;

  int checks = 0;
  int errors = 0;

  pipe_adder #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero),
    .neg       (neg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        co;
    logic        ov;
    logic        z;
    logic        n;
  } vec_t;

  typedef struct {
    logic [15:0] s;
    logic [3:0]  f;
  } res_t;

  res_t exp_q[$];

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // plain integer arithmetic: unsigned for carry, signed for overflow
  function automatic res_t model(logic [15:0] x, logic [15:0] y,
                                 logic c);
    res_t        r;
    int unsigned u;
    int          s;
    u = x + y + c;
    s = int'($signed(x)) + int'($signed(y)) + int'(c);
    r.s = u[15:0];
    r.f = {u[16], (s > 32767) || (s < -32768),
           r.s == 16'h0000, r.s[15]};
    return r;
  endfunction

  logic        hold_p = 1'b0;
  logic [19:0] held;
  res_t        r_pop;

  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      hold_p = 1'b0;
    end else begin
      if (hold_p)
        chk("hold", {sum, cout, ovf, zero, neg}, held);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_out act=%h exp=none", sum);
        end else begin
          r_pop = exp_q.pop_front();
          chk("sb_sum", sum, r_pop.s);
          chk("sb_flags", {cout, ovf, zero, neg}, r_pop.f);
        end
      end
      if (in_valid && in_ready)
        exp_q.push_back(model(a, b, cin));
      hold_p = out_valid && !out_ready;
      held   = {sum, cout, ovf, zero, neg};
    end
  end

  vec_t        tbl[6];
  logic [15:0] got[$];
  int          gotc[$];
  int          k;
  int          sent;
  int          cyc;

  initial begin
    tbl[0] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100,
               1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{16'h0005, 16'h0003, 1'b1, 16'h0009,
               1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000,
               1'b0, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000,
               1'b1, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000,
               1'b1, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF,
               1'b1, 1'b0, 1'b0, 1'b1};

    rst       = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    out_ready = 1'b0;

    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_flags", {cout, ovf, zero, neg}, 0);
    chk("rst_in_ready", in_ready, 0);

    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("post_rst_ready", in_ready, 1);

    // directed vectors with latency check
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      a   = tbl[i].a;
      b   = tbl[i].b;
      cin = tbl[i].cin;
      @(negedge clk);
      chk("vec_in_ready", in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("vec_lat_early", out_valid, 0);
      @(negedge clk);
      chk("vec_out_valid", out_valid, 1);
      chk("vec_sum", sum, tbl[i].s);
      chk("vec_flags", {cout, ovf, zero, neg},
          {tbl[i].co, tbl[i].ov, tbl[i].z, tbl[i].n});
    end

    // backpressure: three back-to-back pairs, sink stalled 4 cycles
    k = 0;
    got.delete();
    gotc.delete();
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      out_ready = (c >= 4);
      in_valid  = (k < 3);
      a   = 16'(k + 1);
      b   = 16'(k + 1);
      cin = 1'b0;
      @(negedge clk);
      if (c == 2 || c == 3) begin
        chk("bp_in_ready", in_ready, 0);
        chk("bp_hold_sum", sum, 16'h0002);
        chk("bp_hold_valid", out_valid, 1);
      end
      if (out_valid && out_ready) begin
        got.push_back(sum);
        gotc.push_back(c);
      end
      if (in_valid && in_ready) k++;
    end
    chk("bp_accepted", k, 3);
    chk("bp_count", got.size(), 3);
    if (got.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        chk("bp_order", got[i], 16'(2 * (i + 1)));
        chk("bp_consec", gotc[i], gotc[0] + i);
      end
    end

    // full throughput with sink always ready
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      in_valid  = (c < 8);
      a   = 16'($urandom);
      b   = 16'($urandom);
      cin = 1'($urandom);
      @(negedge clk);
      if (c >= 2) chk("thru_valid", out_valid, 1);
    end

    // reset with both stages full
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a = 16'h1111;
    b = 16'h2222;
    @(posedge clk);
    #1;
    a = 16'h3333;
    b = 16'h4444;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("mid_full_valid", out_valid, 1);
    chk("mid_full_ready", in_ready, 0);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_sum", sum, 0);
    chk("mid_rst_flags", {cout, ovf, zero, neg}, 0);
    chk("mid_rst_ready", in_ready, 0);
    @(posedge clk);
    #1;
    rst       = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("mid_post_ready", in_ready, 1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("mid_no_stale", out_valid, 0);
    end

    // random stream with random sink backpressure
    sent = 0;
    cyc  = 0;
    while ((sent < 16 || exp_q.size() != 0) && cyc < 300) begin
      @(posedge clk);
      #1;
      in_valid  = (sent < 16) && ($urandom_range(3) != 0);
      a         = 16'($urandom);
      b         = 16'($urandom);
      cin       = 1'($urandom);
      out_ready = 1'($urandom);
      @(negedge clk);
      if (in_valid && in_ready) sent++;
      cyc++;
    end
    chk("rand_sent", sent, 16);
    chk("rand_in_time", (cyc < 300), 1);

    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
